// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// FSM state encodings, line-read type and arbitration mode selectors.
package mem_arb_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

  localparam logic [2:0] LINE_TYPE = 3'b100;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: rotating-pointer round-robin or fixed lowest-index priority.
// The pointer moves past the winner only when the caller reports an accept.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned PRIO_MODE = PRIO_RR,
  localparam int unsigned IdxW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;

  // Scan starting at the pointer (RR) or at index 0 (fixed); first requester wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (PRIO_MODE == PRIO_FIXED) begin
        cand = IdxW'(k);
      end else begin
        cand = IdxW'((32'(ptr_q) + k) % N);
      end
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        grant_idx_o = cand;
      end
    end
    if (found) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (PRIO_MODE == PRIO_RR && advance_i && found) begin
      ptr_d = (grant_idx_o == IdxW'(N - 1)) ? '0 : grant_idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel memory request arbiter with independent read and write paths,
// per-transaction owner tracking for return beats and read-after-write blocking.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned OFFSET_W  = 4,
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_rd_req,
  input  logic [3*NUM_CH-1:0]        ch_rd_type,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_rd_addr,
  output logic [NUM_CH-1:0]          ch_rd_rdy,
  output logic [NUM_CH-1:0]          ch_ret_valid,
  output logic                       ch_ret_last,
  output logic [DATA_W-1:0]          ch_ret_data,
  input  logic [NUM_CH-1:0]          ch_wr_req,
  input  logic [3*NUM_CH-1:0]        ch_wr_type,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_wr_addr,
  input  logic [4*NUM_CH-1:0]        ch_wr_wstrb,
  input  logic [LINE_W*NUM_CH-1:0]   ch_wr_data,
  output logic [NUM_CH-1:0]          ch_wr_rdy,
  output logic                       mem_rd_req,
  output logic [2:0]                 mem_rd_type,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_rd_rdy,
  input  logic                       mem_ret_valid,
  input  logic                       mem_ret_last,
  input  logic [DATA_W-1:0]          mem_ret_data,
  output logic                       mem_wr_req,
  output logic [2:0]                 mem_wr_type,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [3:0]                 mem_wr_wstrb,
  output logic [LINE_W-1:0]          mem_wr_data,
  input  logic                       mem_wr_rdy,
  input  logic                       mem_wr_done,
  output logic                       err_unexp_ret
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam int unsigned LnW  = ADDR_W - OFFSET_W;

  logic [ADDR_W-1:0] rd_addr_a  [NUM_CH];
  logic [2:0]        rd_type_a  [NUM_CH];
  logic [ADDR_W-1:0] wr_addr_a  [NUM_CH];
  logic [2:0]        wr_type_a  [NUM_CH];
  logic [3:0]        wr_wstrb_a [NUM_CH];
  logic [LINE_W-1:0] wr_data_a  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign rd_addr_a[g]  = ch_rd_addr[g*ADDR_W +: ADDR_W];
    assign rd_type_a[g]  = ch_rd_type[g*3 +: 3];
    assign wr_addr_a[g]  = ch_wr_addr[g*ADDR_W +: ADDR_W];
    assign wr_type_a[g]  = ch_wr_type[g*3 +: 3];
    assign wr_wstrb_a[g] = ch_wr_wstrb[g*4 +: 4];
    assign wr_data_a[g]  = ch_wr_data[g*LINE_W +: LINE_W];
  end

  rd_state_e         rd_state_q, rd_state_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [IdxW-1:0]   rd_owner_q, rd_owner_d;
  logic [IdxW-1:0]   wr_owner_q, wr_owner_d;
  logic [LnW-1:0]    wr_line_q, wr_line_d;
  logic              err_q, err_d;

  logic [NUM_CH-1:0] rd_elig, raw_hit, rd_grant, wr_grant;
  logic [IdxW-1:0]   rd_win, wr_win;
  logic              rd_accept, wr_accept;

  // Write side first: its accept feeds the RAW check of the read side.
  assign mem_wr_req   = resetn && (wr_state_q == WR_IDLE) && (|ch_wr_req);
  assign wr_accept    = mem_wr_req && mem_wr_rdy;
  assign mem_wr_type  = wr_type_a[wr_win];
  assign mem_wr_addr  = wr_addr_a[wr_win];
  assign mem_wr_wstrb = wr_wstrb_a[wr_win];
  assign mem_wr_data  = wr_data_a[wr_win];
  assign ch_wr_rdy    = (resetn && wr_state_q == WR_IDLE && mem_wr_rdy) ? wr_grant : '0;

  always_comb begin
    raw_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      raw_hit[i] = ((wr_state_q == WR_WAIT) && (rd_addr_a[i][ADDR_W-1:OFFSET_W] == wr_line_q))
                || (wr_accept && (rd_addr_a[i][ADDR_W-1:OFFSET_W] ==
                                  mem_wr_addr[ADDR_W-1:OFFSET_W]));
    end
  end

  assign rd_elig     = ch_rd_req & ~raw_hit;
  assign mem_rd_req  = resetn && (rd_state_q == RD_IDLE) && (|rd_elig);
  assign rd_accept   = mem_rd_req && mem_rd_rdy;
  assign mem_rd_type = rd_type_a[rd_win];
  assign mem_rd_addr = rd_addr_a[rd_win];
  assign ch_rd_rdy   = (resetn && rd_state_q == RD_IDLE && mem_rd_rdy) ? rd_grant : '0;

  always_comb begin
    ch_ret_valid = '0;
    if (resetn && rd_state_q == RD_WAIT && mem_ret_valid) begin
      ch_ret_valid[rd_owner_q] = 1'b1;
    end
  end

  assign ch_ret_last   = mem_ret_last;
  assign ch_ret_data   = mem_ret_data;
  assign err_unexp_ret = err_q;

  rr_arbiter #(
    .N        (NUM_CH),
    .PRIO_MODE(PRIO_MODE)
  ) u_rd_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (rd_elig),
    .advance_i  (rd_accept),
    .grant_o    (rd_grant),
    .grant_idx_o(rd_win)
  );

  rr_arbiter #(
    .N        (NUM_CH),
    .PRIO_MODE(PRIO_MODE)
  ) u_wr_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (ch_wr_req),
    .advance_i  (wr_accept),
    .grant_o    (wr_grant),
    .grant_idx_o(wr_win)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_owner_d = rd_owner_q;
    err_d      = err_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (mem_ret_valid) begin
          err_d = 1'b1;
        end
        if (rd_accept) begin
          rd_owner_d = rd_win;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ret_valid && mem_ret_last) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    wr_line_d  = wr_line_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (wr_accept) begin
          wr_owner_d = wr_win;
          wr_line_d  = mem_wr_addr[ADDR_W-1:OFFSET_W];
          wr_state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem_wr_done) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_owner_q <= '0;
      wr_owner_q <= '0;
      wr_line_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_owner_q <= rd_owner_d;
      wr_owner_q <= wr_owner_d;
      wr_line_q  <= wr_line_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a table of single-cycle arbitration/RAW
// vectors from reset, plus hand sequences for beats, rotation, priority and reset.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [2:0]        ch_rd_req, ch_wr_req;
  logic [2:0][2:0]   rd_type_a, wr_type_a;
  logic [2:0][31:0]  rd_addr_a, wr_addr_a;
  logic [2:0][3:0]   wstrb_a;
  logic [2:0][127:0] wdata_a;
  logic              mem_rd_rdy, mem_wr_rdy, mem_wr_done;
  logic              mem_ret_valid, mem_ret_last;
  logic [31:0]       mem_ret_data;

  logic [2:0]   ch_rd_rdy, ch_wr_rdy, ch_ret_valid;
  logic         ch_ret_last, mem_rd_req, mem_wr_req, err_unexp_ret;
  logic [31:0]  ch_ret_data, mem_rd_addr, mem_wr_addr;
  logic [2:0]   mem_rd_type, mem_wr_type;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;

  logic [2:0]   fp_ch_rd_rdy, fp_ch_wr_rdy, fp_ch_ret_valid;
  logic         fp_ch_ret_last, fp_mem_rd_req, fp_mem_wr_req, fp_err_unexp_ret;
  logic [31:0]  fp_ch_ret_data, fp_mem_rd_addr, fp_mem_wr_addr;
  logic [2:0]   fp_mem_rd_type, fp_mem_wr_type;
  logic [3:0]   fp_mem_wr_wstrb;
  logic [127:0] fp_mem_wr_data;

  mem_req_arbiter #(.PRIO_MODE(PRIO_RR)) dut (
    .clk(clk), .resetn(resetn),
    .ch_rd_req(ch_rd_req), .ch_rd_type(rd_type_a), .ch_rd_addr(rd_addr_a),
    .ch_rd_rdy(ch_rd_rdy), .ch_ret_valid(ch_ret_valid), .ch_ret_last(ch_ret_last),
    .ch_ret_data(ch_ret_data),
    .ch_wr_req(ch_wr_req), .ch_wr_type(wr_type_a), .ch_wr_addr(wr_addr_a),
    .ch_wr_wstrb(wstrb_a), .ch_wr_data(wdata_a), .ch_wr_rdy(ch_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .mem_wr_done(mem_wr_done), .err_unexp_ret(err_unexp_ret)
  );

  mem_req_arbiter #(.PRIO_MODE(PRIO_FIXED)) dut_fp (
    .clk(clk), .resetn(resetn),
    .ch_rd_req(ch_rd_req), .ch_rd_type(rd_type_a), .ch_rd_addr(rd_addr_a),
    .ch_rd_rdy(fp_ch_rd_rdy), .ch_ret_valid(fp_ch_ret_valid), .ch_ret_last(fp_ch_ret_last),
    .ch_ret_data(fp_ch_ret_data),
    .ch_wr_req(ch_wr_req), .ch_wr_type(wr_type_a), .ch_wr_addr(wr_addr_a),
    .ch_wr_wstrb(wstrb_a), .ch_wr_data(wdata_a), .ch_wr_rdy(fp_ch_wr_rdy),
    .mem_rd_req(fp_mem_rd_req), .mem_rd_type(fp_mem_rd_type), .mem_rd_addr(fp_mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(fp_mem_wr_req), .mem_wr_type(fp_mem_wr_type), .mem_wr_addr(fp_mem_wr_addr),
    .mem_wr_wstrb(fp_mem_wr_wstrb), .mem_wr_data(fp_mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .mem_wr_done(mem_wr_done), .err_unexp_ret(fp_err_unexp_ret)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_rd_req = '0; ch_wr_req = '0;
    rd_type_a = '0; wr_type_a = '0; rd_addr_a = '0; wr_addr_a = '0;
    wstrb_a = '0; wdata_a = '0;
    mem_rd_rdy = 1'b0; mem_wr_rdy = 1'b0; mem_wr_done = 1'b0;
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    string            name;
    logic [2:0]       rd_req;
    logic [2:0][31:0] rd_addr;
    logic [2:0]       wr_req;
    logic [2:0][31:0] wr_addr;
    logic             mrd_rdy;
    logic             mwr_rdy;
    logic [2:0]       exp_rd_rdy;
    logic [2:0]       exp_wr_rdy;
    logic             exp_mrd_req;
    logic [31:0]      exp_mrd_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"single", 3'b010, {32'h0, 32'h1fc0_0010, 32'h0}, 3'b000, '0,
                1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 32'h1fc0_0010};
    vecs[1] = '{"all_rd", 3'b111, {32'h300, 32'h200, 32'h100}, 3'b000, '0,
                1'b1, 1'b1, 3'b001, 3'b000, 1'b1, 32'h100};
    vecs[2] = '{"rd_stall", 3'b111, {32'h300, 32'h200, 32'h100}, 3'b000, '0,
                1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 32'h100};
    vecs[3] = '{"raw_same", 3'b001, {32'h0, 32'h0, 32'h100c}, 3'b100, {32'h1000, 32'h0, 32'h0},
                1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 32'h0};
    vecs[4] = '{"diff_line", 3'b001, {32'h0, 32'h0, 32'h2000}, 3'b100, {32'h1000, 32'h0, 32'h0},
                1'b1, 1'b1, 3'b001, 3'b100, 1'b1, 32'h2000};
    vecs[5] = '{"wr_stall", 3'b001, {32'h0, 32'h0, 32'h100c}, 3'b100, {32'h1000, 32'h0, 32'h0},
                1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 32'h100c};
    vecs[6] = '{"raw_pick", 3'b110, {32'h2000, 32'h100c, 32'h0}, 3'b001, {32'h0, 32'h0, 32'h1004},
                1'b1, 1'b1, 3'b100, 3'b001, 1'b1, 32'h2000};
    vecs[7] = '{"wr_pair", 3'b000, '0, 3'b110, {32'h3000, 32'h2000, 32'h0},
                1'b1, 1'b1, 3'b000, 3'b010, 1'b0, 32'h0};

    // Reset forces handshakes low even with requests pending.
    resetn = 1'b0;
    clear_inputs();
    ch_rd_req = 3'b111; ch_wr_req = 3'b111; mem_rd_rdy = 1'b1; mem_wr_rdy = 1'b1;
    mem_ret_valid = 1'b1;
    tick();
    check("rst_mem_rd_req", 64'(mem_rd_req), 64'(1'b0));
    check("rst_mem_wr_req", 64'(mem_wr_req), 64'(1'b0));
    check("rst_rd_rdy", 64'(ch_rd_rdy), 64'(3'b000));
    check("rst_wr_rdy", 64'(ch_wr_rdy), 64'(3'b000));
    check("rst_ret_valid", 64'(ch_ret_valid), 64'(3'b000));
    do_reset();
    #1;
    check("rst_err", 64'(err_unexp_ret), 64'(1'b0));

    for (int v = 0; v < 8; v++) begin
      do_reset();
      ch_rd_req = vecs[v].rd_req; rd_addr_a = vecs[v].rd_addr;
      ch_wr_req = vecs[v].wr_req; wr_addr_a = vecs[v].wr_addr;
      mem_rd_rdy = vecs[v].mrd_rdy; mem_wr_rdy = vecs[v].mwr_rdy;
      #1;
      check({vecs[v].name, "_rd_rdy"}, 64'(ch_rd_rdy), 64'(vecs[v].exp_rd_rdy));
      check({vecs[v].name, "_wr_rdy"}, 64'(ch_wr_rdy), 64'(vecs[v].exp_wr_rdy));
      check({vecs[v].name, "_mrd_req"}, 64'(mem_rd_req), 64'(vecs[v].exp_mrd_req));
      if (vecs[v].exp_mrd_req) begin
        check({vecs[v].name, "_mrd_addr"}, 64'(mem_rd_addr), 64'(vecs[v].exp_mrd_addr));
      end
    end

    // Line read from ch1 with four beats routed only to ch1.
    do_reset();
    ch_rd_req = 3'b010; rd_type_a[1] = LINE_TYPE; rd_addr_a[1] = 32'h1fc0_0010;
    mem_rd_rdy = 1'b1;
    #1;
    check("line_addr", 64'(mem_rd_addr), 64'h1fc0_0010);
    check("line_type", 64'(mem_rd_type), 64'(LINE_TYPE));
    check("line_rdy", 64'(ch_rd_rdy), 64'(3'b010));
    tick();
    ch_rd_req = 3'b000;
    for (int b = 0; b < 4; b++) begin
      mem_ret_valid = 1'b1; mem_ret_last = (b == 3); mem_ret_data = 32'hA0 + 32'(b);
      #1;
      check("beat_valid", 64'(ch_ret_valid), 64'(3'b010));
      check("beat_last", 64'(ch_ret_last), 64'(b == 3));
      check("beat_data", 64'(ch_ret_data), 64'(32'hA0 + 32'(b)));
      tick();
    end
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    ch_rd_req = 3'b001;
    #1;
    check("line_back_idle", 64'(ch_rd_rdy), 64'(3'b001));
    check("line_no_err", 64'(err_unexp_ret), 64'(1'b0));

    // Round-robin rotation over three held requesters, one beat each.
    do_reset();
    ch_rd_req = 3'b111; mem_rd_rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [2:0] exp_oh;
      exp_oh = 3'b001 << (t % 3);
      #1;
      check("rr_grant", 64'(ch_rd_rdy), 64'(exp_oh));
      tick();
      check("rr_wait_rdy", 64'(ch_rd_rdy), 64'(3'b000));
      mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
      #1;
      check("rr_owner", 64'(ch_ret_valid), 64'(exp_oh));
      tick();
      mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    end

    // Fixed priority: ch0 beats ch2 until ch0 drops.
    do_reset();
    ch_rd_req = 3'b101; mem_rd_rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) ch_rd_req = 3'b100;
      #1;
      check("fp_grant", 64'(fp_ch_rd_rdy), (t == 3) ? 64'(3'b100) : 64'(3'b001));
      tick();
      mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
      tick();
      mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    end

    // RAW across a long in-flight write.
    do_reset();
    ch_wr_req = 3'b001; wr_addr_a[0] = 32'h0000_1000; mem_wr_rdy = 1'b1;
    #1;
    check("raw_wr_acc", 64'(ch_wr_rdy), 64'(3'b001));
    tick();
    ch_wr_req = 3'b000;
    ch_rd_req = 3'b110; rd_addr_a[1] = 32'h0000_100c; rd_addr_a[2] = 32'h0000_2000;
    mem_rd_rdy = 1'b1;
    #1;
    check("raw_other_line", 64'(ch_rd_rdy), 64'(3'b100));
    check("raw_other_addr", 64'(mem_rd_addr), 64'h0000_2000);
    tick();
    ch_rd_req = 3'b010;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
    tick();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) mem_wr_done = 1'b1;
      #1;
      check("raw_blocked_rdy", 64'(ch_rd_rdy), 64'(3'b000));
      check("raw_blocked_req", 64'(mem_rd_req), 64'(1'b0));
      tick();
    end
    mem_wr_done = 1'b0;
    #1;
    check("raw_released", 64'(ch_rd_rdy), 64'(3'b010));

    // Reset mid-burst, pointer back to 0, then an unexpected beat.
    do_reset();
    ch_rd_req = 3'b010; rd_addr_a[1] = 32'h400; mem_rd_rdy = 1'b1;
    tick();
    ch_rd_req = 3'b000;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("midrst_ret_valid", 64'(ch_ret_valid), 64'(3'b000));
    tick();
    resetn = 1'b1; mem_ret_valid = 1'b0;
    ch_rd_req = 3'b111;
    #1;
    check("midrst_ptr0", 64'(ch_rd_rdy), 64'(3'b001));
    check("midrst_err_clear", 64'(err_unexp_ret), 64'(1'b0));
    ch_rd_req = 3'b000;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
    #1;
    check("unexp_dropped", 64'(ch_ret_valid), 64'(3'b000));
    tick();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    check("unexp_err_set", 64'(err_unexp_ret), 64'(1'b1));
    tick();
    check("unexp_err_sticky", 64'(err_unexp_ret), 64'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
